// File: rtl/ss_wbslv.sv
// ss_wbslv: Wishbone slave memory responder standing in for the host bridge.
// Answers 64-bit descriptor fetches and buffer bursts (low word on dat, high
// word on dat64), with programmable wait states, an out-of-range / trapped
// address error path and optional retry injection.
// Build option: define SS_WBSLV_RTY_EN to build retry injection and rty_cnt;
// without it wbm_rty and rty_cnt are tied to 0 and RTY_PERIOD is ignored.
//
// state  | meaning
// S_IDLE | no cycle in progress, waiting for cyc & stb
// S_WAIT | counting wait states before the next beat
// S_BEAT | terminating beats (ack / rty / err) while req is high
// S_HOLD | error returned, silent until the master drops cyc
module ss_wbslv #(
    parameter int unsigned AW         = 10,
    parameter logic [31:0] BASE       = 32'h0,
    parameter int unsigned WAIT_CYC   = 1,
    parameter int unsigned RTY_PERIOD = 0
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbm_cyc,
    input  logic        wbm_stb,
    input  logic        wbm_we,
    input  logic        wbm_cab,
    input  logic [3:0]  wbm_sel,
    input  logic [31:0] wbm_adr,
    input  logic [31:0] wbm_dat_i,
    input  logic [31:0] wbm_dat64_i,
    output logic [31:0] wbm_dat_o,
    output logic [31:0] wbm_dat64_o,
    output logic        wbm_ack,
    output logic        wbm_rty,
    output logic        wbm_err,
    input  logic        err_adr_en,
    input  logic [28:0] err_adr,
    output logic [15:0] beat_cnt,
    output logic [7:0]  rty_cnt
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned HW    = 29 - AW;
    localparam logic [HW-1:0] BASE_V = BASE[HW-1:0];
    // First beat waits WAIT_CYC (at least one cycle); a new single beat after
    // an ack also pays the ack-to-wait turnaround, hence the extra count.
    localparam logic [4:0] WAIT_LD  = 5'(WAIT_CYC);
    localparam logic [4:0] WAIT_RLD = 5'(WAIT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT, S_HOLD} state_t;

    state_t        r_state, w_state_nxt;
    logic [4:0]    r_wcnt, w_wcnt_nxt;
    logic [15:0]   r_beat_cnt;
    logic [63:0]   r_mem [DEPTH];

    logic          w_req;
    logic          w_bad_adr;
    logic          w_rty_cond;
    logic          w_ack, w_rty, w_err;
    logic [AW-1:0] w_idx;
    logic [63:0]   w_rd;
    logic          w_unused;

    assign w_req     = wbm_cyc & wbm_stb;
    assign w_idx     = wbm_adr[AW+2:3];
    assign w_rd      = r_mem[w_idx];
    assign w_bad_adr = (wbm_adr[31:AW+3] != BASE_V) ||
                       (err_adr_en && (wbm_adr[31:3] == err_adr));
    // sel is deliberately ignored: the master drives sel=0 on data writes.
    assign w_unused  = ^{wbm_sel, wbm_adr[2:0]};

`ifdef SS_WBSLV_RTY_EN
    localparam int unsigned RTY_DIV = (RTY_PERIOD == 0) ? 1 : RTY_PERIOD;

    logic        r_rty_done;
    logic [7:0]  r_rty_cnt;
    logic [31:0] w_beat_mod;

    assign w_beat_mod = {16'd0, r_beat_cnt} % RTY_DIV;
    // After one retry the repeated beat at the same address must ack.
    assign w_rty_cond = (RTY_PERIOD != 0) && !r_rty_done &&
                        (w_beat_mod == RTY_DIV - 1);
    assign rty_cnt    = r_rty_cnt;

    // Retry bookkeeping: one-shot flag per beat and saturating retry count.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_rty_done <= 1'b0;
            r_rty_cnt  <= 8'h00;
        end else begin
            if (w_rty) begin
                r_rty_done <= 1'b1;
                if (r_rty_cnt != 8'hFF)
                    r_rty_cnt <= r_rty_cnt + 8'd1;
            end else if (w_ack || !wbm_cyc) begin
                r_rty_done <= 1'b0;
            end
        end
    end
`else
    assign w_rty_cond = 1'b0;
    assign rty_cnt    = 8'h00;
`endif

    // State, wait counter and beat counter registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state    <= S_IDLE;
            r_wcnt     <= 5'd0;
            r_beat_cnt <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
            if (w_ack)
                r_beat_cnt <= r_beat_cnt + 16'd1;
        end
    end

    // Next state and combinational termination; every termination needs req.
    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        w_ack       = 1'b0;
        w_rty       = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_state_nxt = S_WAIT;
                    w_wcnt_nxt  = WAIT_LD;
                end
            end
            S_WAIT: begin
                w_wcnt_nxt = (r_wcnt == 5'd0) ? 5'd0 : r_wcnt - 5'd1;
                if (r_wcnt <= 5'd1)
                    w_state_nxt = S_BEAT;
            end
            S_BEAT: begin
                if (w_req) begin
                    if (w_bad_adr) begin
                        w_err       = 1'b1;
                        w_state_nxt = S_HOLD;
                    end else if (w_rty_cond) begin
                        w_rty = 1'b1;
                    end else begin
                        w_ack = 1'b1;
                        if (!wbm_cab) begin
                            w_state_nxt = S_WAIT;
                            w_wcnt_nxt  = WAIT_RLD;
                        end
                    end
                end
            end
            S_HOLD: begin
                w_state_nxt = S_HOLD;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (!wbm_cyc)
            w_state_nxt = S_IDLE;
    end

    // Write commits at the edge closing the ack cycle; reset suppresses it.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i && w_ack && wbm_we)
            r_mem[w_idx] <= {wbm_dat64_i, wbm_dat_i};
    end

    assign wbm_ack     = w_ack;
    assign wbm_rty     = w_rty;
    assign wbm_err     = w_err;
    assign wbm_dat_o   = w_ack ? w_rd[31:0]  : 32'h0;
    assign wbm_dat64_o = w_ack ? w_rd[63:32] : 32'h0;
    assign beat_cnt    = r_beat_cnt;

endmodule

// File: tb/tb_ss_wbslv.sv
// Bench for ss_wbslv: a bus driver issues directed bursts and queues the
// hand-computed read data; a monitor pops and compares on every read ack.
module tb_ss_wbslv;

    localparam int WC = 1;
    localparam int RP = 3;
`ifdef SS_WBSLV_RTY_EN
    localparam int EXP_RTY = 2;
`else
    localparam int EXP_RTY = 0;
`endif

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        wbm_cyc = 1'b0, wbm_stb = 1'b0, wbm_we = 1'b0, wbm_cab = 1'b0;
    logic [3:0]  wbm_sel = 4'h0;
    logic [31:0] wbm_adr = 32'h0, wbm_dat_i = 32'h0, wbm_dat64_i = 32'h0;
    logic [31:0] wbm_dat_o, wbm_dat64_o;
    logic        wbm_ack, wbm_rty, wbm_err;
    logic        err_adr_en = 1'b0;
    logic [28:0] err_adr = 29'h0;
    logic [15:0] beat_cnt;
    logic [7:0]  rty_cnt;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    ss_wbslv #(.AW(10), .BASE(32'h0), .WAIT_CYC(WC), .RTY_PERIOD(RP)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .wbm_cyc(wbm_cyc), .wbm_stb(wbm_stb), .wbm_we(wbm_we), .wbm_cab(wbm_cab),
        .wbm_sel(wbm_sel), .wbm_adr(wbm_adr),
        .wbm_dat_i(wbm_dat_i), .wbm_dat64_i(wbm_dat64_i),
        .wbm_dat_o(wbm_dat_o), .wbm_dat64_o(wbm_dat64_o),
        .wbm_ack(wbm_ack), .wbm_rty(wbm_rty), .wbm_err(wbm_err),
        .err_adr_en(err_adr_en), .err_adr(err_adr),
        .beat_cnt(beat_cnt), .rty_cnt(rty_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: read data on acks, bus protocol rules every cycle.
    always @(negedge wb_clk_i) begin
        if (!wb_rst_i) begin
            chk("term_onehot", 64'($onehot0({wbm_ack, wbm_rty, wbm_err})), 64'd1);
            if (!(wbm_cyc && wbm_stb))
                chk("term_without_req", 64'({wbm_ack, wbm_rty, wbm_err}), 64'd0);
            if (wbm_ack && !wbm_we) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_read_ack", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("read_data", {wbm_dat64_o, wbm_dat_o}, {e.hi, e.lo});
                end
            end else if (!wbm_ack) begin
                chk("data_idle_zero", {wbm_dat64_o, wbm_dat_o}, 64'd0);
            end
        end
    end

    task automatic do_reset();
        @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
    endtask

    // Cycle 0 is the cycle in which cyc/stb are first driven.
    task automatic burst(input logic we, input logic cab, input logic [31:0] a0,
                         input int n, input logic [31:0] lo0, input logic [31:0] hi0,
                         input int hold, output int acks, output int rtys,
                         output int errs, output int first_ack, output int last_ack);
        int  beat = 0;
        int  cyc_n = 0;
        logic acked;
        acks = 0; rtys = 0; errs = 0; first_ack = -1; last_ack = -1;
        @(posedge wb_clk_i); #1;
        wbm_cyc = 1'b1; wbm_stb = 1'b1; wbm_we = we; wbm_cab = cab;
        wbm_adr = a0; wbm_dat_i = lo0; wbm_dat64_i = hi0;
        if (!we) exp_q.push_back({hi0, lo0});
        while (beat < n && errs == 0 && cyc_n < 100) begin
            @(negedge wb_clk_i);
            acked = wbm_ack;
            if (wbm_ack) begin
                acks++;
                if (first_ack < 0) first_ack = cyc_n;
                last_ack = cyc_n;
            end else if (wbm_rty) begin
                rtys++;
            end else if (wbm_err) begin
                errs++;
                if (!we) void'(exp_q.pop_back());
            end
            @(posedge wb_clk_i); #1;
            cyc_n++;
            if (acked) begin
                beat++;
                if (beat < n) begin
                    wbm_adr     = a0 + 32'(8 * beat);
                    wbm_dat_i   = lo0 + 32'(beat);
                    wbm_dat64_i = hi0 + 32'(beat);
                    if (!we) exp_q.push_back({hi0 + 32'(beat), lo0 + 32'(beat)});
                end
            end
        end
        if (cyc_n >= 100) chk("burst_timeout", 64'd1, 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge wb_clk_i);
            chk("hold_quiet", 64'({wbm_ack, wbm_rty, wbm_err}), 64'd0);
            @(posedge wb_clk_i); #1;
        end
        wbm_cyc = 1'b0; wbm_stb = 1'b0; wbm_we = 1'b0; wbm_cab = 1'b0;
        @(negedge wb_clk_i);
        chk("no_extra_term", 64'({wbm_ack, wbm_rty, wbm_err}), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int a, r, e, f, l;
        bit done;
        int beat;
        logic acked;

        // Reset state
        repeat (2) @(negedge wb_clk_i);
        chk("rst_term", 64'({wbm_ack, wbm_rty, wbm_err}), 64'd0);
        chk("rst_data", {wbm_dat64_o, wbm_dat_o}, 64'd0);
        chk("rst_beat_cnt", 64'(beat_cnt), 64'd0);
        chk("rst_rty_cnt", 64'(rty_cnt), 64'd0);
        wb_rst_i = 1'b0;

        // Preload word 0x40/0x41, then cab read of 2 beats
        burst(1'b1, 1'b1, 32'h200, 2, 32'h0010_0040, 32'h0000_1000, 0, a, r, e, f, l);
        chk("preload_acks", 64'(a), 64'd2);
        do_reset();
        burst(1'b0, 1'b1, 32'h200, 2, 32'h0010_0040, 32'h0000_1000, 0, a, r, e, f, l);
        chk("cab_rd_first_ack", 64'(f), 64'd2);
        chk("cab_rd_last_ack", 64'(l), 64'd3);
        chk("cab_rd_beat_cnt", 64'(beat_cnt), 64'd2);

        // Single-beat throughput: one beat per WAIT_CYC+2 cycles
        do_reset();
        burst(1'b0, 1'b0, 32'h200, 2, 32'h0010_0040, 32'h0000_1000, 0, a, r, e, f, l);
        chk("single_first_ack", 64'(f), 64'd2);
        chk("single_last_ack", 64'(l), 64'(2 + WC + 2));

        // Write burst 0..3 at 0x800 with sel=0, read back
        do_reset();
        burst(1'b1, 1'b1, 32'h800, 4, 32'h0, 32'h0, 0, a, r, e, f, l);
        chk("wr4_acks", 64'(a), 64'd4);
        chk("wr4_consecutive", 64'(l - f), 64'(3 + r));
        burst(1'b0, 1'b1, 32'h800, 4, 32'h0, 32'h0, 0, a, r, e, f, l);
        chk("rd4_acks", 64'(a), 64'd4);

        // Retry injection on a 6-beat cab read
        burst(1'b1, 1'b1, 32'h820, 2, 32'h4, 32'h4, 0, a, r, e, f, l);
        do_reset();
        burst(1'b0, 1'b1, 32'h800, 6, 32'h0, 32'h0, 0, a, r, e, f, l);
        chk("rty6_acks", 64'(a), 64'd6);
        chk("rty6_rtys", 64'(r), 64'(EXP_RTY));
        chk("rty6_span", 64'(l - f), 64'(5 + EXP_RTY));
        chk("rty6_beat_cnt", 64'(beat_cnt), 64'd6);
        chk("rty6_rty_cnt", 64'(rty_cnt), 64'(EXP_RTY));

        // Error-address trap at 0x808, then slave is idle again
        do_reset();
        err_adr_en = 1'b1;
        err_adr    = 29'h101;
        burst(1'b0, 1'b1, 32'h800, 2, 32'h0, 32'h0, 3, a, r, e, f, l);
        chk("trap_acks", 64'(a), 64'd1);
        chk("trap_errs", 64'(e), 64'd1);
        err_adr_en = 1'b0;
        burst(1'b0, 1'b0, 32'h808, 1, 32'h1, 32'h1, 0, a, r, e, f, l);
        chk("after_trap_ack", 64'(a), 64'd1);

        // Out-of-range write must err and leave word 0 intact
        burst(1'b1, 1'b0, 32'h0, 1, 32'h1111_1111, 32'h2222_2222, 0, a, r, e, f, l);
        burst(1'b1, 1'b0, 32'h1_0000, 1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1, a, r, e, f, l);
        chk("oor_errs", 64'(e), 64'd1);
        chk("oor_acks", 64'(a), 64'd0);
        burst(1'b0, 1'b0, 32'h0, 1, 32'h1111_1111, 32'h2222_2222, 0, a, r, e, f, l);

        // Reset during the ack of the 4th write beat
        burst(1'b1, 1'b0, 32'hA18, 1, 32'h0000_AAAA, 32'h0000_BBBB, 0, a, r, e, f, l);
        do_reset();
        @(posedge wb_clk_i); #1;
        wbm_cyc = 1'b1; wbm_stb = 1'b1; wbm_we = 1'b1; wbm_cab = 1'b1;
        wbm_adr = 32'hA00; wbm_dat_i = 32'h60; wbm_dat64_i = 32'h60;
        done = 1'b0;
        beat = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge wb_clk_i);
            if (wbm_ack && beat == 3) begin
                wb_rst_i = 1'b1;
                #1;
                chk("midrst_ack", 64'(wbm_ack), 64'd0);
                chk("midrst_beat_cnt", 64'(beat_cnt), 64'd0);
                chk("midrst_data", {wbm_dat64_o, wbm_dat_o}, 64'd0);
                done = 1'b1;
            end else begin
                acked = wbm_ack;
                @(posedge wb_clk_i); #1;
                if (acked) begin
                    beat++;
                    wbm_adr     = 32'hA00 + 32'(8 * beat);
                    wbm_dat_i   = 32'h60 + 32'(beat);
                    wbm_dat64_i = 32'h60 + 32'(beat);
                end
            end
        end
        if (!done) chk("midrst_timeout", 64'd1, 64'd0);
        @(posedge wb_clk_i); #1;
        wbm_cyc = 1'b0; wbm_stb = 1'b0; wbm_we = 1'b0; wbm_cab = 1'b0;
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        burst(1'b0, 1'b1, 32'hA00, 3, 32'h60, 32'h60, 0, a, r, e, f, l);
        chk("midrst_rd_acks", 64'(a), 64'd3);
        burst(1'b0, 1'b0, 32'hA18, 1, 32'h0000_AAAA, 32'h0000_BBBB, 0, a, r, e, f, l);

        repeat (3) @(negedge wb_clk_i);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
